// File: rtl/fixed_cast_pkg.sv
// rtl/fixed_cast_pkg.sv - shared helpers for the fixed-point cast path
//
// Purpose: shift-amount and parameter-legality functions used by the
// widening stream and its per-lane widener.
// Ports: none (package).
package fixed_cast_pkg;

  // Left shift that re-aligns the binary point from the input to the output format.
  function automatic int widen_shift(int in_frac_width, int out_frac_width);
    return out_frac_width - in_frac_width;
  endfunction

  // A widening cast is lossless only if neither the fraction nor the integer part
  // (sign included) gets narrower.
  function automatic bit widen_params_legal(int in_width, int in_frac_width,
                                            int out_width, int out_frac_width);
    return (in_width > 0) && (in_frac_width >= 0) && (out_frac_width >= 0) &&
           (out_frac_width >= in_frac_width) &&
           ((out_width - out_frac_width) >= (in_width - in_frac_width));
  endfunction

endpackage

// File: rtl/fixed_widen.sv
// rtl/fixed_widen.sv - single-lane signed sign-extend-and-shift
//
// Purpose: re-expresses one narrow two's-complement fixed-point value in a wider
// format with more fractional bits. Purely combinational.
// Ports:
//   din   in   IN_WIDTH   narrow signed value
//   dout  out  OUT_WIDTH  din sign-extended to OUT_WIDTH, shifted left by SHIFT
module fixed_widen #(
  parameter int IN_WIDTH  = 3,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 2
) (
  input  logic [IN_WIDTH-1:0]  din,
  output logic [OUT_WIDTH-1:0] dout
);

  logic signed [OUT_WIDTH-1:0] ext;

  // The signed cast makes the size cast replicate the sign bit; the shifted-out
  // top bits are guaranteed to be sign copies by the legality check.
  assign ext  = OUT_WIDTH'($signed(din));
  assign dout = ext <<< SHIFT;

endmodule

// File: rtl/fixed_widening_stream.sv
// rtl/fixed_widening_stream.sv - streaming lossless fixed-point up-caster
//
// Purpose: accepts IN_SIZE lanes of narrow signed fixed-point values per beat and
// returns each lane widened to OUT_WIDTH/OUT_FRAC_WIDTH, one cycle later, under a
// shared valid/ready handshake with a registered output.
// Optional feature macro: FIXED_WIDENING_SKID_EN adds a one-entry skid register so
// data_in_ready is a flop with no combinational path from data_out_ready.
// Ports:
//   clk             in   1                  clock, rising edge
//   rst             in   1                  synchronous active-high reset
//   data_in         in   IN_SIZE*IN_WIDTH   lane i at [i*IN_WIDTH +: IN_WIDTH]
//   data_in_valid   in   1                  producer has a beat
//   data_in_ready   out  1                  block can take a beat
//   data_out        out  IN_SIZE*OUT_WIDTH  lane i at [i*OUT_WIDTH +: OUT_WIDTH]
//   data_out_valid  out  1                  data_out holds a beat
//   data_out_ready  in   1                  consumer takes the beat
module fixed_widening_stream #(
  parameter int IN_SIZE        = 3,
  parameter int IN_WIDTH       = 3,
  parameter int IN_FRAC_WIDTH  = 1,
  parameter int OUT_WIDTH      = 8,
  parameter int OUT_FRAC_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_SIZE*IN_WIDTH-1:0]   data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic [IN_SIZE*OUT_WIDTH-1:0]  data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ready
);
  import fixed_cast_pkg::*;

  localparam int SHIFT = widen_shift(IN_FRAC_WIDTH, OUT_FRAC_WIDTH);
  localparam int BEAT_W = IN_SIZE * OUT_WIDTH;

  if (!widen_params_legal(IN_WIDTH, IN_FRAC_WIDTH, OUT_WIDTH, OUT_FRAC_WIDTH)) begin : g_param_err
    $error("fixed_widening_stream: cast from %0d.%0d to %0d.%0d is not lossless",
           IN_WIDTH, IN_FRAC_WIDTH, OUT_WIDTH, OUT_FRAC_WIDTH);
  end

  logic [BEAT_W-1:0] widened;

  for (genvar g = 0; g < IN_SIZE; g++) begin : g_lane
    fixed_widen #(
      .IN_WIDTH (IN_WIDTH),
      .OUT_WIDTH(OUT_WIDTH),
      .SHIFT    (SHIFT)
    ) u_widen (
      .din (data_in[g*IN_WIDTH +: IN_WIDTH]),
      .dout(widened[g*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  logic              ovalid_q, ovalid_d;
  logic [BEAT_W-1:0] odata_q, odata_d;
  logic              out_free;
  logic              accept;

`ifdef FIXED_WIDENING_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [BEAT_W-1:0] skid_data_q, skid_data_d;

  always_comb begin
    out_free     = !ovalid_q || data_out_ready;
    accept       = data_in_valid && !skid_valid_q;
    ovalid_d     = ovalid_q;
    odata_d      = odata_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_free) begin
      // The parked beat is older than anything on data_in, so it goes first;
      // accept is necessarily low while the skid is occupied.
      if (skid_valid_q) begin
        ovalid_d     = 1'b1;
        odata_d      = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        ovalid_d = accept;
        if (accept) odata_d = widened;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = widened;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  // Registered ready: drops the cycle after the skid fills.
  assign data_in_ready = !skid_valid_q;
`else
  always_comb begin
    out_free = !ovalid_q || data_out_ready;
    accept   = data_in_valid && out_free;
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    if (out_free) begin
      ovalid_d = accept;
      if (accept) odata_d = widened;
    end
  end

  assign data_in_ready = out_free;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ovalid_q <= 1'b0;
      odata_q  <= '0;
    end else begin
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
    end
  end

  assign data_out_valid = ovalid_q;
  assign data_out       = odata_q;

endmodule

// File: tb/tb_fixed_widening_stream.sv
// tb/tb_fixed_widening_stream.sv - self-checking bench for fixed_widening_stream
module tb_fixed_widening_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [8:0]  data_in;
  logic        data_in_valid, data_in_ready;
  logic [23:0] data_out;
  logic        data_out_valid, data_out_ready;

  logic [15:0] w_in;
  logic        w_valid, w_in_ready;
  logic [31:0] w_out;
  logic        w_out_valid, w_out_ready;

  fixed_widening_stream #(
    .IN_SIZE(3), .IN_WIDTH(3), .IN_FRAC_WIDTH(1), .OUT_WIDTH(8), .OUT_FRAC_WIDTH(3)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
  );

  fixed_widening_stream #(
    .IN_SIZE(2), .IN_WIDTH(8), .IN_FRAC_WIDTH(4), .OUT_WIDTH(16), .OUT_FRAC_WIDTH(8)
  ) dut_wide (
    .clk(clk), .rst(rst),
    .data_in(w_in), .data_in_valid(w_valid), .data_in_ready(w_in_ready),
    .data_out(w_out), .data_out_valid(w_out_valid), .data_out_ready(w_out_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Reference: decode the 3-bit code as a signed integer, scale by 2^2.
  function automatic logic [7:0] ref_lane(input logic [2:0] x);
    int v;
    v = x[2] ? int'(x) - 8 : int'(x);
    return 8'(v * 4);
  endfunction

  function automatic logic [23:0] ref_beat(input logic [8:0] b);
    logic [23:0] r;
    logic [2:0]  l;
    for (int j = 0; j < 3; j++) begin
      l = b[j*3 +: 3];
      r[j*8 +: 8] = ref_lane(l);
    end
    return r;
  endfunction

  logic [23:0] exp_q[$];
  int          n_in = 0, n_out = 0;
  bit          took;
  logic        rdy_seen, ov_seen;
  logic [23:0] out_seen;

  // One clock of scoreboarded traffic; inputs must be set before the call.
  task automatic cycle();
    @(negedge clk);
    rdy_seen = data_in_ready;
    ov_seen  = data_out_valid;
    out_seen = data_out;
    took     = data_in_valid && data_in_ready;
    if (took) begin
      exp_q.push_back(ref_beat(data_in));
      n_in++;
    end
    if (data_out_valid && data_out_ready) begin
      n_out++;
      if (exp_q.size() == 0) fail_now("spurious_beat");
      else check("stream_data", 32'(data_out), 32'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] sweep_beat(input int i);
    logic [8:0] b;
    for (int j = 0; j < 3; j++) b[j*3 +: 3] = 3'((i + 3*j) % 8);
    return b;
  endfunction

  typedef struct {
    logic [8:0]  din;
    logic [23:0] dout;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n_acc, guard, cnt, in0, out0, idx;

    tbl[0] = '{din: 9'b111_100_011, dout: 24'hFCF00C};
    tbl[1] = '{din: 9'b000_001_010, dout: 24'h000408};
    tbl[2] = '{din: 9'b101_110_011, dout: 24'hF4F80C};
    tbl[3] = '{din: 9'b010_111_000, dout: 24'h08FC00};
    tbl[4] = '{din: 9'b100_100_100, dout: 24'hF0F0F0};
    tbl[5] = '{din: 9'b011_011_011, dout: 24'h0C0C0C};

    rst = 1'b1; data_in = '0; data_in_valid = 1'b0; data_out_ready = 1'b0;
    w_in = '0; w_valid = 1'b0; w_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(data_out_valid), 32'd0);
    check("reset_data", 32'(data_out), 32'd0);
    check("reset_ready", 32'(data_in_ready), 32'd1);
    check("reset_wide_data", w_out, 32'd0);

    // First cycle after reset accepts; single beat appears one cycle later.
    rst = 1'b0;
    data_in = 9'b111_100_011; data_in_valid = 1'b1; data_out_ready = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    check("single_valid", 32'(data_out_valid), 32'd1);
    check("single_data", 32'(data_out), 32'h00FCF00C);
    @(posedge clk); #1;
    check("single_valid_drop", 32'(data_out_valid), 32'd0);

    // Table vectors, back to back.
    for (int i = 0; i < 6; i++) begin
      data_in = tbl[i].din; data_in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_valid", i), 32'(data_out_valid), 32'd1);
      check($sformatf("tbl%0d_data", i), 32'(data_out), 32'(tbl[i].dout));
    end
    data_in_valid = 1'b0;
    @(posedge clk); #1;
    check("tbl_idle", 32'(data_out_valid), 32'd0);

    // Back-pressure: 5 stalled cycles with valid held high.
    data_out_ready = 1'b0; data_in_valid = 1'b1; data_in = 9'b011_010_001;
    n_acc = 0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (took) begin
        n_acc++;
        data_in = 9'b101_110_111;
      end
      if (c == 0) check("bp_ready_c0", 32'(rdy_seen), 32'd1);
`ifdef FIXED_WIDENING_SKID_EN
      if (c == 1) check("bp_ready_c1", 32'(rdy_seen), 32'd1);
`else
      if (c == 1) check("bp_ready_c1", 32'(rdy_seen), 32'd0);
`endif
      if (c >= 2) check($sformatf("bp_ready_c%0d", c), 32'(rdy_seen), 32'd0);
      if (c >= 1) begin
        check($sformatf("bp_hold_valid_c%0d", c), 32'(ov_seen), 32'd1);
        check($sformatf("bp_stable_c%0d", c), 32'(out_seen), 32'h000C0804);
      end
    end
`ifdef FIXED_WIDENING_SKID_EN
    check("bp_accepts", n_acc, 2);
`else
    check("bp_accepts", n_acc, 1);
`endif
    data_in_valid = 1'b0; data_out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      cycle();
      guard++;
    end
    check("bp_drained", exp_q.size(), 0);
    cycle();

    // 16-beat stream with ready high: no bubbles.
    in0 = n_in; cnt = 0;
    data_in_valid = 1'b1;
    for (int b = 0; b < 16; b++) begin
      data_in = 9'(b * 37);
      cycle();
      if (b >= 1 && ov_seen) cnt++;
    end
    data_in_valid = 1'b0;
    cycle();
    if (ov_seen) cnt++;
    check("stream16_accepts", n_in - in0, 16);
    check("stream16_valid_cycles", cnt, 16);
    cycle();

    // Every code on every lane, random valid and ready.
    in0 = n_in; out0 = n_out; idx = 0; guard = 0;
    while ((idx < 24 || exp_q.size() > 0) && guard < 800) begin
      data_in        = sweep_beat(idx);
      data_in_valid  = (idx < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
      data_out_ready = 1'($urandom_range(0, 1));
      cycle();
      if (took) idx++;
      guard++;
    end
    if (guard >= 800) fail_now("sweep_timeout");
    check("sweep_in_count", n_in - in0, 24);
    check("sweep_out_count", n_out - out0, 24);

    // Reset while the output register (and skid, if present) is full.
    data_out_ready = 1'b0; data_in_valid = 1'b1; data_in = 9'b001_001_001;
    repeat (3) cycle();
    rst = 1'b1; data_in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_valid", 32'(data_out_valid), 32'd0);
    check("rst_mid_data", 32'(data_out), 32'd0);
    check("rst_mid_ready", 32'(data_in_ready), 32'd1);
    rst = 1'b0;
    exp_q.delete();
    data_out_ready = 1'b1;
    out0 = n_out;
    repeat (6) cycle();
    check("rst_no_stale", n_out - out0, 0);
    check("rst_ready_after", 32'(rdy_seen), 32'd1);

    // Wide parameter set: extreme codes.
    w_in = {8'h7F, 8'h80}; w_valid = 1'b1; w_out_ready = 1'b1;
    @(posedge clk); #1;
    w_valid = 1'b0;
    check("wide_valid", 32'(w_out_valid), 32'd1);
    check("wide_lane0_80", 32'(w_out[15:0]), 32'h0000F800);
    check("wide_lane1_7f", 32'(w_out[31:16]), 32'h000007F0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
